// File: rtl/instr_fetch_unit_pkg.sv
// Shared widths and instruction-word field positions for the fetch front end.
// Pure constants, so there is no latency or backpressure.
package instr_fetch_unit_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int OPC_W  = 6;
    localparam int VAL_W  = 8;

    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 10;
    localparam int REG_S_BIT = 9;
    localparam int ACC_S_BIT = 8;
    localparam int VAL_MSB   = 7;

endpackage

// File: rtl/instr_fetch_unit_mem.sv
// Instruction memory with a synchronous write port and an asynchronous read port.
// Reads have 0-cycle latency. It has no backpressure: a write is accepted on every enabled edge.
module instr_fetch_unit_mem
    import instr_fetch_unit_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
) (
    input  logic          clk,
    input  logic          en_write,
    input  logic [AW-1:0] address,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out
);

    // The contents are not reset. The async read lets this map onto distributed RAM.
    logic [DW-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (en_write) begin
            mem[address] <= data_in;
        end
    end

    assign data_out = mem[address];

endmodule

// File: rtl/instr_fetch_unit_reg.sv
// Instruction register that splits the current word into its decode fields.
// Latency is 1 cycle. It loads on every edge, so there is no backpressure.
module instr_fetch_unit_reg
    import instr_fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instr,
    output logic [OPC_W-1:0]  op_code,
    output logic              reg_s,
    output logic              acc_s,
    output logic [VAL_W-1:0]  val
);

    logic [DATA_W-1:0] ir_d;
    logic [DATA_W-1:0] ir_q;

    always_comb begin
        ir_d = instr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q <= '0;
        end else begin
            ir_q <= ir_d;
        end
    end

    assign op_code = ir_q[OPC_MSB:OPC_LSB];
    assign reg_s   = ir_q[REG_S_BIT];
    assign acc_s   = ir_q[ACC_S_BIT];
    assign val     = ir_q[VAL_MSB:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: the instruction memory feeds the instruction register, and the top only wires them together.
// Fields are valid 1 cycle after the address changes. There is no backpressure.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [OPC_W-1:0]  op_code,
    output logic              reg_s,
    output logic              acc_s,
    output logic [VAL_W-1:0]  val
);

    logic [DATA_W-1:0] im_rd_dat;

    instr_fetch_unit_mem #(
        .AW(ADDR_W),
        .DW(DATA_W)
    ) u_mem (
        .clk      (clk),
        .en_write (en_write),
        .address  (address),
        .data_in  (data_in),
        .data_out (im_rd_dat)
    );

    instr_fetch_unit_reg u_reg (
        .clk     (clk),
        .rst     (rst),
        .instr   (im_rd_dat),
        .op_code (op_code),
        .reg_s   (reg_s),
        .acc_s   (acc_s),
        .val     (val)
    );

    assign data_out = im_rd_dat;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. Inputs change on the falling edge, and outputs are sampled 1ns after the rising edge.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_write;
    logic [9:0]  address;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic [5:0]  op_code;
    logic        reg_s;
    logic        acc_s;
    logic [7:0]  val;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk      (clk),
        .rst      (rst),
        .en_write (en_write),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .op_code  (op_code),
        .reg_s    (reg_s),
        .acc_s    (acc_s),
        .val      (val)
    );

    // The decoded fields are reassembled into a single word so that one comparison covers all of them.
    function automatic logic [15:0] fields();
        return {op_code, reg_s, acc_s, val};
    endfunction

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en_write = 1'b0; address = '0; data_in = '0;
        #1;
        total_cnt++;
        if (fields() !== 16'h0000)
            $display("FAIL reset_async fields=%h want=0000", fields());
        else pass_cnt++;
        edge_sample();
        total_cnt++;
        if (fields() !== 16'h0000)
            $display("FAIL reset_hold fields=%h want=0000", fields());
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load();
        logic [15:0] words [4] = '{16'h040D, 16'h280C, 16'h2C14, 16'h080D};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            en_write = 1'b1; address = 10'(i); data_in = words[i];
            edge_sample();
            total_cnt++;
            if (data_out !== words[i])
                $display("FAIL load_%0d data_out=%h want=%h", i, data_out, words[i]);
            else pass_cnt++;
        end
        @(negedge clk);
        en_write = 1'b0;
    endtask

    task automatic test_readback();
        @(negedge clk);
        address = 10'd0;
        #1;
        total_cnt++;
        if (data_out !== 16'h040D)
            $display("FAIL readback_comb data_out=%h want=040D", data_out);
        else pass_cnt++;
        edge_sample();
        total_cnt++;
        if (fields() !== 16'h040D || op_code !== 6'h01 || val !== 8'h0D)
            $display("FAIL readback_ir fields=%h want=040D", fields());
        else pass_cnt++;
    endtask

    task automatic test_seq_fetch();
        logic [15:0] exp_w [3] = '{16'h280C, 16'h2C14, 16'h080D};
        logic [5:0]  exp_o [3] = '{6'h0A, 6'h0B, 6'h02};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            address = 10'(i + 1);
            #1;
            // The register must still hold the previous word until the next edge.
            total_cnt++;
            if (fields() === exp_w[i])
                $display("FAIL seq_early_%0d fields=%h want!=%h", i + 1, fields(), exp_w[i]);
            else pass_cnt++;
            edge_sample();
            total_cnt++;
            if (fields() !== exp_w[i] || op_code !== exp_o[i])
                $display("FAIL seq_fetch_%0d fields=%h want=%h", i + 1, fields(), exp_w[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_flags();
        @(negedge clk);
        en_write = 1'b1; address = 10'd4; data_in = 16'hFF3C;
        edge_sample();
        @(negedge clk);
        en_write = 1'b0;
        edge_sample();
        total_cnt++;
        if (op_code !== 6'h3F || reg_s !== 1'b1 || acc_s !== 1'b1 || val !== 8'h3C)
            $display("FAIL flags fields=%h want=FF3C", fields());
        else pass_cnt++;
    endtask

    task automatic test_boundary();
        // Top address.
        @(negedge clk);
        en_write = 1'b1; address = 10'd1023; data_in = 16'hA5C3;
        edge_sample();
        @(negedge clk);
        en_write = 1'b0;
        edge_sample();
        total_cnt++;
        if (data_out !== 16'hA5C3 || op_code !== 6'h29 || reg_s !== 1'b0 ||
            acc_s !== 1'b1 || val !== 8'hC3)
            $display("FAIL addr1023 data_out=%h fields=%h want=A5C3", data_out, fields());
        else pass_cnt++;
        @(negedge clk);
        address = 10'd0;
        #1;
        total_cnt++;
        if (data_out !== 16'h040D)
            $display("FAIL no_alias data_out=%h want=040D", data_out);
        else pass_cnt++;

        // When a write hits the word being fetched, the register captures the pre-write word.
        @(negedge clk);
        en_write = 1'b1; address = 10'd1; data_in = 16'h5555;
        edge_sample();
        total_cnt++;
        if (fields() !== 16'h280C || data_out !== 16'h5555)
            $display("FAIL write_capture fields=%h data_out=%h want=280C/5555", fields(), data_out);
        else pass_cnt++;
        @(negedge clk);
        en_write = 1'b0;
        edge_sample();
        total_cnt++;
        if (op_code !== 6'h15 || acc_s !== 1'b1 || val !== 8'h55)
            $display("FAIL after_write fields=%h want=5555", fields());
        else pass_cnt++;

        // Assert reset away from any edge, then write while reset is held.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (fields() !== 16'h0000)
            $display("FAIL mid_rst_async fields=%h want=0000", fields());
        else pass_cnt++;
        @(negedge clk);
        en_write = 1'b1; address = 10'd2; data_in = 16'h7777;
        edge_sample();
        total_cnt++;
        if (fields() !== 16'h0000 || data_out !== 16'h7777)
            $display("FAIL rst_write fields=%h data_out=%h want=0000/7777", fields(), data_out);
        else pass_cnt++;
        @(negedge clk);
        en_write = 1'b0; address = 10'd1023;
        #1;
        total_cnt++;
        if (data_out !== 16'hA5C3)
            $display("FAIL rst_retain data_out=%h want=A5C3", data_out);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0; address = 10'd3;
        #1;
        total_cnt++;
        if (fields() !== 16'h0000)
            $display("FAIL rst_release_hold fields=%h want=0000", fields());
        else pass_cnt++;
        edge_sample();
        total_cnt++;
        if (fields() !== 16'h080D)
            $display("FAIL rst_reload fields=%h want=080D", fields());
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_readback();
        test_seq_fetch();
        test_flags();
        test_boundary();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
